traffic_fsm: RTL and testbench

- Master of the timer handshake. Sequences main-street and side-street lights plus a pedestrian walk phase.
- Each phase is loaded into the existing Timer as start_timer plus input_value. The next phase is chosen when expired returns.
- Sits between the sensor/button inputs and the lamp drivers. It is the only source of timer start requests in the controller.

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/traffic_fsm_input_sync.sv | 36 +++
 rtl/traffic_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_traffic_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller:
// state codes, lamp encodings and default phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_MG     = 3'd1,
    ST_MY     = 3'd2,
    ST_SG     = 3'd3,
    ST_SG_EXT = 3'd4,
    ST_SY     = 3'd5,
    ST_WALK   = 3'd6
  } state_e;

  // Lamp bit order is {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int T_MAIN_DEF = 7;
  localparam int T_SIDE_DEF = 5;
  localparam int T_YEL_DEF  = 2;
  localparam int T_EXT_DEF  = 3;
  localparam int T_WALK_DEF = 6;

  // A zero duration would never let the timer expire, so it is bumped to 1.
  function automatic logic [3:0] clamp_dur(input int d);
    logic [3:0] r;
    if (d < 1) begin
      r = 4'd1;
    end else if (d > 15) begin
      r = 4'd15;
    end else begin
      r = 4'(d);
    end
    return r;
  endfunction

endpackage

// File: rtl/traffic_fsm_input_sync.sv
// Two-flop synchronizer for an asynchronous input, with a registered
// rising-edge pulse aligned to the synchronized level.
module input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic rise_q, rise_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    rise_d = meta_q & ~sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/traffic_fsm.sv
// Traffic light sequencer: drives the external timer with one start strobe
// per phase entry and advances on a guarded expiry from that timer.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int T_MAIN = T_MAIN_DEF,
  parameter int T_SIDE = T_SIDE_DEF,
  parameter int T_YEL  = T_YEL_DEF,
  parameter int T_EXT  = T_EXT_DEF,
  parameter int T_WALK = T_WALK_DEF
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       car_sensor,
  input  logic       walk_button,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] input_value,
  output logic       timer_enable,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] D_MAIN = clamp_dur(T_MAIN);
  localparam logic [3:0] D_SIDE = clamp_dur(T_SIDE);
  localparam logic [3:0] D_YEL  = clamp_dur(T_YEL);
  localparam logic [3:0] D_EXT  = clamp_dur(T_EXT);
  localparam logic [3:0] D_WALK = clamp_dur(T_WALK);

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] value_q, value_d;
  logic       guard_q, guard_d;
  logic       armed_q, armed_d;
  logic       walk_pending_q, walk_pending_d;
  logic       ext_used_q, ext_used_d;
  logic       timer_enable_q, timer_enable_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;

  logic       sensor_sync, sensor_rise_unused;
  logic       walk_rise, walk_level_unused;
  logic       fire, walk_req, enter;
  state_e     nxt_state;
  logic [3:0] nxt_dur;

  input_sync u_sensor_sync (
    .clk     (clk),
    .rst_n   (sys_reset_n),
    .async_i (car_sensor),
    .level_o (sensor_sync),
    .rise_o  (sensor_rise_unused)
  );

  input_sync u_walk_sync (
    .clk     (clk),
    .rst_n   (sys_reset_n),
    .async_i (walk_button),
    .level_o (walk_level_unused),
    .rise_o  (walk_rise)
  );

  // Expiry only counts once armed, two cycles after the strobe, so a stale
  // expired level left over from the previous phase cannot skip a phase.
  always_comb begin
    state_d        = state_q;
    start_d        = 1'b0;
    value_d        = value_q;
    guard_d        = start_q;
    armed_d        = armed_q | guard_q;
    walk_pending_d = walk_pending_q;
    ext_used_d     = ext_used_q;
    timer_enable_d = 1'b1;
    enter          = 1'b0;
    nxt_state      = ST_INIT;
    nxt_dur        = D_MAIN;
    fire           = armed_q & expired;
    walk_req       = walk_pending_q | walk_rise;

    if (walk_rise && (state_q != ST_WALK)) begin
      walk_pending_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        enter     = 1'b1;
        nxt_state = ST_MG;
        nxt_dur   = D_MAIN;
      end
      ST_MG: begin
        if (fire) begin
          enter = 1'b1;
          if (sensor_sync || walk_req) begin
            nxt_state = ST_MY;
            nxt_dur   = D_YEL;
          end else begin
            nxt_state = ST_MG;
            nxt_dur   = D_MAIN;
          end
        end
      end
      ST_MY: begin
        if (fire) begin
          enter = 1'b1;
          if (walk_req) begin
            nxt_state = ST_WALK;
            nxt_dur   = D_WALK;
          end else begin
            nxt_state  = ST_SG;
            nxt_dur    = D_SIDE;
            ext_used_d = 1'b0;
          end
        end
      end
      ST_SG: begin
        if (fire) begin
          enter = 1'b1;
          if (sensor_sync && !ext_used_q) begin
            nxt_state  = ST_SG_EXT;
            nxt_dur    = D_EXT;
            ext_used_d = 1'b1;
          end else begin
            nxt_state = ST_SY;
            nxt_dur   = D_YEL;
          end
        end
      end
      ST_SG_EXT: begin
        if (fire) begin
          enter     = 1'b1;
          nxt_state = ST_SY;
          nxt_dur   = D_YEL;
        end
      end
      ST_SY: begin
        if (fire) begin
          enter = 1'b1;
          if (walk_req) begin
            nxt_state = ST_WALK;
            nxt_dur   = D_WALK;
          end else begin
            nxt_state = ST_MG;
            nxt_dur   = D_MAIN;
          end
        end
      end
      ST_WALK: begin
        if (fire) begin
          enter     = 1'b1;
          nxt_state = ST_MG;
          nxt_dur   = D_MAIN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (enter) begin
      state_d = nxt_state;
      start_d = 1'b1;
      value_d = nxt_dur;
      armed_d = 1'b0;
      if (nxt_state == ST_WALK) begin
        walk_pending_d = 1'b0;
      end
    end
  end

  // Lamps are decoded from the next state so the registered lamps line up
  // with the state register on the same clock.
  always_comb begin
    main_d = LAMP_RED;
    side_d = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      ST_MG:     main_d = LAMP_GRN;
      ST_MY:     main_d = LAMP_YEL;
      ST_SG:     side_d = LAMP_GRN;
      ST_SG_EXT: side_d = LAMP_GRN;
      ST_SY:     side_d = LAMP_YEL;
      ST_WALK:   walk_d = 1'b1;
      default:   walk_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q        <= ST_INIT;
      start_q        <= 1'b0;
      value_q        <= 4'd0;
      guard_q        <= 1'b0;
      armed_q        <= 1'b0;
      walk_pending_q <= 1'b0;
      ext_used_q     <= 1'b0;
      timer_enable_q <= 1'b0;
      main_q         <= LAMP_RED;
      side_q         <= LAMP_RED;
      walk_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      value_q        <= value_d;
      guard_q        <= guard_d;
      armed_q        <= armed_d;
      walk_pending_q <= walk_pending_d;
      ext_used_q     <= ext_used_d;
      timer_enable_q <= timer_enable_d;
      main_q         <= main_d;
      side_q         <= side_d;
      walk_q         <= walk_d;
    end
  end

  assign start_timer  = start_q;
  assign input_value  = value_q;
  assign timer_enable = timer_enable_q;
  assign main_light   = main_q;
  assign side_light   = side_q;
  assign walk         = walk_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: each expected phase entry is queued by
// the stimulus and checked by a monitor whenever start_timer pulses.
module tb_traffic_fsm;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_MG   = 3'd1;
  localparam logic [2:0] S_MY   = 3'd2;
  localparam logic [2:0] S_SG   = 3'd3;
  localparam logic [2:0] S_SGX  = 3'd4;
  localparam logic [2:0] S_SY   = 3'd5;
  localparam logic [2:0] S_WALK = 3'd6;

  localparam int RED = 4;
  localparam int YEL = 2;
  localparam int GRN = 1;

  typedef struct {
    logic [2:0] st;
    int         val;
    int         mainl;
    int         sidel;
    int         wlk;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       car_sensor = 1'b0;
  logic       walk_button = 1'b0;
  logic       expired;
  logic       start_timer;
  logic [3:0] input_value;
  logic       timer_enable;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] state_dbg;

  logic hold_exp = 1'b0;
  logic exp_r = 1'b0;
  int   tcnt = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic chk_pulse = 1'b0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  traffic_fsm dut (
    .clk          (clk),
    .sys_reset_n  (sys_reset_n),
    .car_sensor   (car_sensor),
    .walk_button  (walk_button),
    .expired      (expired),
    .start_timer  (start_timer),
    .input_value  (input_value),
    .timer_enable (timer_enable),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk         (walk),
    .state_dbg    (state_dbg)
  );

  // Behavioural timer: expired rises input_value*4 cycles after the load.
  always @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      tcnt  <= 0;
      exp_r <= 1'b0;
    end else if (start_timer) begin
      tcnt  <= int'(input_value) * 4;
      exp_r <= 1'b0;
    end else if (tcnt > 1) begin
      tcnt <= tcnt - 1;
    end else if (tcnt == 1) begin
      tcnt  <= 0;
      exp_r <= 1'b1;
    end
  end

  assign expired = exp_r | hold_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic pushExp(input logic [2:0] st, input int gap);
    exp_t e;
    e.st = st; e.gap = gap; e.wlk = 0; e.mainl = RED; e.sidel = RED; e.val = 0;
    case (st)
      S_MG:    begin e.val = 7; e.mainl = GRN; end
      S_MY:    begin e.val = 2; e.mainl = YEL; end
      S_SG:    begin e.val = 5; e.sidel = GRN; end
      S_SGX:   begin e.val = 3; e.sidel = GRN; end
      S_SY:    begin e.val = 2; e.sidel = YEL; end
      S_WALK:  begin e.val = 6; e.wlk = 1; end
      default: e.val = 0;
    endcase
    sbq.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the queue, including the
  // number of cycles since the previous strobe (or since reset release).
  always @(negedge clk) begin
    if (chk_pulse) begin
      checkOutput("strobe_width", int'(start_timer), 0);
      chk_pulse = 1'b0;
    end
    if (sys_reset_n && start_timer) begin
      chk_pulse = 1'b1;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_strobe_state", int'(state_dbg), -1);
      end else begin
        exp_t e;
        int   gap;
        e = sbq.pop_front();
        gap = cyc - last_cyc;
        last_cyc = cyc;
        checkOutput("entry_state", int'(state_dbg), int'(e.st));
        checkOutput("entry_value", int'(input_value), e.val);
        checkOutput("entry_main", int'(main_light), e.mainl);
        checkOutput("entry_side", int'(side_light), e.sidel);
        checkOutput("entry_walk", int'(walk), e.wlk);
        checkOutput("entry_enable", int'(timer_enable), 1);
        if (e.gap > 0) checkOutput("entry_gap", gap, e.gap);
      end
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_state"}, int'(state_dbg), int'(S_INIT));
    checkOutput({tag, "_main"}, int'(main_light), RED);
    checkOutput({tag, "_side"}, int'(side_light), RED);
    checkOutput({tag, "_walk"}, int'(walk), 0);
    checkOutput({tag, "_start"}, int'(start_timer), 0);
    checkOutput({tag, "_value"}, int'(input_value), 0);
    checkOutput({tag, "_enable"}, int'(timer_enable), 0);
  endtask

  task automatic applyReset(input string tag);
    @(posedge clk);
    #2 sys_reset_n = 1'b0;
    #1 checkReset(tag);
    repeat (2) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic sensor, input logic hold);
    car_sensor = sensor;
    hold_exp   = hold;
    walk_button = 1'b0;
    @(negedge clk);
    sys_reset_n = 1'b1;
    last_cyc = cyc;
    checkOutput("release_state", int'(state_dbg), int'(S_INIT));
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_pending_entries"}, sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 checkReset("por");

    // Idle: MG re-arms every 28+2 cycles with main green.
    applyStimulus(1'b0, 1'b0);
    pushExp(S_MG, 1); pushExp(S_MG, 30); pushExp(S_MG, 30);
    waitDrain("idle", 120);
    #1 checkOutput("idle_main_green", int'(main_light), GRN);
    checkOutput("idle_enable", int'(timer_enable), 1);

    // Sensor held: one side extension per side phase.
    applyReset("rst_a");
    applyStimulus(1'b1, 1'b0);
    pushExp(S_MG, 1); pushExp(S_MY, 30); pushExp(S_SG, 10); pushExp(S_SGX, 22);
    pushExp(S_SY, 14); pushExp(S_MG, 10); pushExp(S_MY, 30);
    waitDrain("sensor", 250);

    // Walk pulse during MG: MY -> WALK -> MG, then request is gone.
    applyReset("rst_b");
    applyStimulus(1'b0, 1'b0);
    pushExp(S_MG, 1); pushExp(S_MY, 30); pushExp(S_WALK, 10);
    pushExp(S_MG, 26); pushExp(S_MG, 30);
    repeat (5) @(posedge clk);
    #1 walk_button = 1'b1;
    repeat (3) @(posedge clk);
    #1 walk_button = 1'b0;
    waitDrain("walk", 250);

    // Walk edge lands in the very cycle MY's expiry is qualified.
    applyReset("rst_c");
    applyStimulus(1'b1, 1'b0);
    pushExp(S_MG, 1); pushExp(S_MY, 30); pushExp(S_WALK, 10);
    pushExp(S_MG, 26); pushExp(S_MY, 30);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(start_timer && state_dbg == S_MY) && n < 200);
    checkOutput("find_my_timeout", int'(n >= 200), 0);
    repeat (7) @(posedge clk);
    #1 walk_button = 1'b1;
    repeat (6) @(posedge clk);
    #1 walk_button = 1'b0;
    waitDrain("walk_edge", 250);

    // Expired stuck high: every state lasts strobe + 2 guard cycles.
    applyReset("rst_d");
    applyStimulus(1'b1, 1'b1);
    pushExp(S_MG, 1); pushExp(S_MY, 3); pushExp(S_SG, 3); pushExp(S_SGX, 3);
    pushExp(S_SY, 3); pushExp(S_MG, 3); pushExp(S_MY, 3);
    waitDrain("stuck_exp", 60);

    // Reset in the middle of SG_EXT, then a clean restart.
    applyReset("rst_e");
    applyStimulus(1'b1, 1'b0);
    pushExp(S_MG, 1); pushExp(S_MY, 30); pushExp(S_SG, 10); pushExp(S_SGX, 22);
    waitDrain("to_sgx", 200);
    repeat (4) @(posedge clk);
    #1 checkOutput("sgx_side_green", int'(side_light), GRN);
    applyReset("rst_mid_sgx");
    applyStimulus(1'b0, 1'b0);
    pushExp(S_MG, 1); pushExp(S_MG, 30);
    waitDrain("restart", 120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
